rename_regfile: RTL and testbench
=================================

// Module: rename_regfile
// PURPOSE
//  Architectural register file with per-register rename tags, on the opposite side of the ROB's
//  commit / rename / dependency-query interface. Takes ROB commits (value + tag release) and ROB
//  tail allocations (rename), and resolves decoder source operands to a value or a pending ROB tag
//  by querying the ROB's rs1/rs2 ready/value ports. Sits between the decoder and the ROB.
// PARAMETERS
//  ROB_W     `ROB_WIDTH_BIT   ROB index width; tag width
//  REG_NUM   32               number of architectural registers; x0 hard-wired 0
// PORTS
//  clk_in          in   1        system clock
//  rst_n_in        in   1        asynchronous, active-low reset
//  rdy_in          in   1        pause when low: no state change
//  clear_flag      in   1        ROB mispredict flush
//  write_reg_id    in   5        commit destination (0 = no commit / x0)
//  write_val       in   32       commit value
//  write_ROB_id    in   ROB_W    ROB entry being committed
//  new_reg_id      in   5        rename destination (0 = no rename)
//  new_ROB_id      in   ROB_W    ROB tail allocated to new_reg_id
//  dec_rs1, dec_rs2 in  5        decoder source register indices
//  rob_rs1_id      out  ROB_W    tag query to ROB (rs1)
//  rob_rs1_ready   in   1        ROB reports tag resolved
//  rob_rs1_val     in   32       ROB resolved value
//  rob_rs2_id / rob_rs2_ready / rob_rs2_val   same for rs2
//  q1_ready        out  1        operand 1 available
//  q1_val          out  32       operand 1 value (valid when q1_ready)
//  q1_tag          out  ROB_W    producing ROB entry (valid when !q1_ready)
//  q2_ready / q2_val / q2_tag     same for operand 2
// BEHAVIOUR
//  State: val[REG_NUM] 32b, busy[REG_NUM], tag[REG_NUM] ROB_W. rst_n_in low (async): all cleared.
//  Outputs are combinational; post-reset: q*_ready=1, q*_val=0, q*_tag=0, rob_rs*_id=0.
//  Sequential update (posedge, rdy_in=1), in order, later wins:
//   1 commit: write_reg_id!=0 -> val<=write_val; busy<=0, tag<=0 only if tag==write_ROB_id
//     (stale commit of an overwritten rename leaves busy set).
//   2 rename: new_reg_id!=0 && !clear_flag -> busy<=1, tag<=new_ROB_id.
//   3 flush: clear_flag -> every busy<=0, tag<=0; val keeps committed state (incl. this-cycle commit).
//  Same-cycle commit+rename of same reg: val from commit, busy=1/tag from rename.
//  rdy_in=0: all state frozen, including flush and commit.
//  Lookup (per source, combinational, independent):
//   x0 -> ready=1, val=0, tag=0.
//   !busy -> ready=1, val=val[r].
//   busy && commit this cycle with write_ROB_id==tag[r] -> ready=1, val=write_val.
//   busy -> rob_rs*_id=tag[r]; rob_rs*_ready -> ready=1,val=rob_rs*_val; else ready=0,tag=tag[r].
//   rob_rs*_id=0 when source not busy.
//  Lookup sees pre-rename state: rename in the same cycle (same instruction, e.g. add x1,x1,x1)
//   never affects its own operands.
//  Tag 0 is a valid ROB index; busy alone qualifies tag validity.
// STRUCTURE
//  const.v: ROB_WIDTH_BIT, REG_NUM, REG_W(5) -- shared with ROB/decoder.
//  Sub-module regfile_read_port: the lookup mux, instantiated twice (rs1, rs2).
// TESTING
//  reset, dec_rs1=5 -> q1_ready=1 q1_val=0; dec_rs1=0 always ready/0 even after commit to x0.
//  rename x3->tag 4; then dec_rs1=3, rob_rs1_ready=0 -> rob_rs1_id=4, q1_ready=0, q1_tag=4.
//   Then rob_rs1_ready=1 rob_rs1_val=0x55 -> q1_ready=1 q1_val=0x55.
//  rename x3->4, rename x3->7, commit x3 tag4 val 9 -> val[3]=9, busy=1, tag=7; commit tag7 val
//   0xA -> busy=0, q_val=0xA.
//  same cycle commit x6 tag2 val 0x11 + rename x6->3 -> val=0x11, busy, tag=3; separately
//   dec_rs2=6 busy tag2 with commit tag2 -> q2_ready=1 q2_val=commit value.
//  renames x1,x2,x5 pending, clear_flag=1 with commit x1 val 7 -> all busy clear, val[1]=7;
//   rdy_in=0 during a clear/commit -> no change; rst_n_in low mid-sequence clears all async.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// Shared widths for the rename register file, ROB and decoder.
// Operand lookup result type is shared by both read ports.
package rename_regfile_pkg;

    localparam int unsigned ROB_WIDTH_BIT = 4;
    localparam int unsigned REG_NUM       = 32;
    localparam int unsigned REG_W         = 5;
    localparam int unsigned XLEN          = 32;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [REG_W-1:0] reg_id_t;

endpackage

// File: rtl/rename_regfile_read_port.sv
// Operand lookup for one decoder source: register value, same-cycle commit
// bypass, ROB forwarding, or a pending ROB tag.
module regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int unsigned ROB_W = ROB_WIDTH_BIT
) (
    input  logic [REG_W-1:0] src,
    input  logic             src_busy,
    input  logic [ROB_W-1:0] src_tag,
    input  logic [XLEN-1:0]  src_val,
    input  logic             commit_en,
    input  logic [ROB_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_val,
    output logic [ROB_W-1:0] rob_id,
    input  logic             rob_ready,
    input  logic [XLEN-1:0]  rob_val,
    output logic             q_ready,
    output logic [XLEN-1:0]  q_val,
    output logic [ROB_W-1:0] q_tag
);

    always_comb begin
        rob_id  = '0;
        q_ready = 1'b1;
        q_val   = '0;
        q_tag   = '0;
        if (src != '0) begin
            if (!src_busy) begin
                q_val = src_val;
            end else begin
                rob_id = src_tag;
                // the producer retiring this very cycle has not reached the array yet
                if (commit_en && commit_tag == src_tag) begin
                    q_val = commit_val;
                end else if (rob_ready) begin
                    q_val = rob_val;
                end else begin
                    q_ready = 1'b0;
                    q_tag   = src_tag;
                end
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags: applies ROB commits and
// renames, and resolves decoder operands to a value or a pending ROB tag.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int unsigned ROB_W   = ROB_WIDTH_BIT,
    parameter int unsigned REG_NUM = rename_regfile_pkg::REG_NUM
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_flag,
    input  logic [REG_W-1:0] write_reg_id,
    input  logic [XLEN-1:0]  write_val,
    input  logic [ROB_W-1:0] write_ROB_id,
    input  logic [REG_W-1:0] new_reg_id,
    input  logic [ROB_W-1:0] new_ROB_id,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    output logic [ROB_W-1:0] rob_rs1_id,
    input  logic             rob_rs1_ready,
    input  logic [XLEN-1:0]  rob_rs1_val,
    output logic [ROB_W-1:0] rob_rs2_id,
    input  logic             rob_rs2_ready,
    input  logic [XLEN-1:0]  rob_rs2_val,
    output logic             q1_ready,
    output logic [XLEN-1:0]  q1_val,
    output logic [ROB_W-1:0] q1_tag,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q2_val,
    output logic [ROB_W-1:0] q2_tag
);

    logic [XLEN-1:0]  val  [REG_NUM];
    logic             busy [REG_NUM];
    logic [ROB_W-1:0] tag  [REG_NUM];

    logic commit_en;
    assign commit_en = (write_reg_id != '0);

    // Commit, then rename, then flush: later steps override earlier ones.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val[i]  <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                val[write_reg_id] <= write_val;
                // a stale commit of an overwritten rename keeps the newer tag busy
                if (tag[write_reg_id] == write_ROB_id) begin
                    busy[write_reg_id] <= 1'b0;
                    tag[write_reg_id]  <= '0;
                end
            end
            if (new_reg_id != '0 && !clear_flag) begin
                busy[new_reg_id] <= 1'b1;
                tag[new_reg_id]  <= new_ROB_id;
            end
            if (clear_flag) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    busy[i] <= 1'b0;
                    tag[i]  <= '0;
                end
            end
        end
    end

    regfile_read_port #(.ROB_W(ROB_W)) u_rs1 (
        .src        (dec_rs1),
        .src_busy   (busy[dec_rs1]),
        .src_tag    (tag[dec_rs1]),
        .src_val    (val[dec_rs1]),
        .commit_en  (commit_en),
        .commit_tag (write_ROB_id),
        .commit_val (write_val),
        .rob_id     (rob_rs1_id),
        .rob_ready  (rob_rs1_ready),
        .rob_val    (rob_rs1_val),
        .q_ready    (q1_ready),
        .q_val      (q1_val),
        .q_tag      (q1_tag)
    );

    regfile_read_port #(.ROB_W(ROB_W)) u_rs2 (
        .src        (dec_rs2),
        .src_busy   (busy[dec_rs2]),
        .src_tag    (tag[dec_rs2]),
        .src_val    (val[dec_rs2]),
        .commit_en  (commit_en),
        .commit_tag (write_ROB_id),
        .commit_val (write_val),
        .rob_id     (rob_rs2_id),
        .rob_ready  (rob_rs2_ready),
        .rob_val    (rob_rs2_val),
        .q_ready    (q2_ready),
        .q_val      (q2_val),
        .q_tag      (q2_tag)
    );

endmodule

// File: tb/tb_rename_regfile.sv
// Directed scoreboard bench for rename_regfile: stimulus pushes hand-computed
// operand expectations, a negedge monitor pops and compares.
module tb_rename_regfile;

    localparam int unsigned RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          rdy_in;
    logic          clear_flag;
    logic [4:0]    write_reg_id;
    logic [31:0]   write_val;
    logic [RW-1:0] write_ROB_id;
    logic [4:0]    new_reg_id;
    logic [RW-1:0] new_ROB_id;
    logic [4:0]    dec_rs1, dec_rs2;
    logic [RW-1:0] rob_rs1_id, rob_rs2_id;
    logic          rob_rs1_ready, rob_rs2_ready;
    logic [31:0]   rob_rs1_val, rob_rs2_val;
    logic          q1_ready, q2_ready;
    logic [31:0]   q1_val, q2_val;
    logic [RW-1:0] q1_tag, q2_tag;

    rename_regfile #(.ROB_W(RW), .REG_NUM(32)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .clear_flag    (clear_flag),
        .write_reg_id  (write_reg_id),
        .write_val     (write_val),
        .write_ROB_id  (write_ROB_id),
        .new_reg_id    (new_reg_id),
        .new_ROB_id    (new_ROB_id),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .rob_rs1_id    (rob_rs1_id),
        .rob_rs1_ready (rob_rs1_ready),
        .rob_rs1_val   (rob_rs1_val),
        .rob_rs2_id    (rob_rs2_id),
        .rob_rs2_ready (rob_rs2_ready),
        .rob_rs2_val   (rob_rs2_val),
        .q1_ready      (q1_ready),
        .q1_val        (q1_val),
        .q1_tag        (q1_tag),
        .q2_ready      (q2_ready),
        .q2_val        (q2_val),
        .q2_tag        (q2_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string         name;
        logic          r1;
        logic [31:0]   v1;
        logic [RW-1:0] t1;
        logic [RW-1:0] id1;
        logic          r2;
        logic [31:0]   v2;
        logic [RW-1:0] t2;
        logic [RW-1:0] id2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // value is only meaningful when ready, tag only when not ready
    task automatic cmp_port(input string name, input int p,
                            input logic gr, input logic [31:0] gv, input logic [RW-1:0] gt,
                            input logic [RW-1:0] gid,
                            input logic er, input logic [31:0] ev, input logic [RW-1:0] et,
                            input logic [RW-1:0] eid);
        logic ok;
        ok = (gr == er) && (gid == eid) && (er ? (gv == ev) : (gt == et));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s q%0d: got ready=%0b val=%h tag=%0d rob_id=%0d, want ready=%0b val=%h tag=%0d rob_id=%0d",
                     name, p, gr, gv, gt, gid, er, ev, et, eid);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_port(e.name, 1, q1_ready, q1_val, q1_tag, rob_rs1_id, e.r1, e.v1, e.t1, e.id1);
                cmp_port(e.name, 2, q2_ready, q2_val, q2_tag, rob_rs2_id, e.r2, e.v2, e.t2, e.id2);
            end
        end
    end

    task automatic expect_ops(input string name,
                              input logic r1, input logic [31:0] v1, input logic [RW-1:0] t1,
                              input logic [RW-1:0] id1,
                              input logic r2, input logic [31:0] v2, input logic [RW-1:0] t2,
                              input logic [RW-1:0] id2);
        exp_t e;
        e.name = name;
        e.r1 = r1; e.v1 = v1; e.t1 = t1; e.id1 = id1;
        e.r2 = r2; e.v2 = v2; e.t2 = t2; e.id2 = id2;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        rdy_in        = 1'b1;
        clear_flag    = 1'b0;
        write_reg_id  = '0;
        write_val     = '0;
        write_ROB_id  = '0;
        new_reg_id    = '0;
        new_ROB_id    = '0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        rob_rs1_ready = 1'b0;
        rob_rs1_val   = '0;
        rob_rs2_ready = 1'b0;
        rob_rs2_val   = '0;
    endtask

    initial begin
        rst_n_in = 1'b0;
        step();
        dec_rs1 = 5;
        expect_ops("reset", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); rst_n_in = 1'b1;
        write_reg_id = 0; write_val = 32'h123; write_ROB_id = 1;
        expect_ops("x0_commit", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); new_reg_id = 3; new_ROB_id = 4; dec_rs1 = 3;
        expect_ops("rename_own_operand", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); dec_rs1 = 3;
        expect_ops("x3_pending", 0, 0, 4, 4, 1, 0, 0, 0);

        step(); dec_rs1 = 3; rob_rs1_ready = 1; rob_rs1_val = 32'h55;
        expect_ops("x3_rob_fwd", 1, 32'h55, 0, 4, 1, 0, 0, 0);

        step(); new_reg_id = 3; new_ROB_id = 7; dec_rs2 = 3;
        expect_ops("x3_rename2", 1, 0, 0, 0, 0, 0, 4, 4);

        step(); write_reg_id = 3; write_ROB_id = 4; write_val = 9; dec_rs1 = 3;
        expect_ops("stale_commit_no_bypass", 0, 0, 7, 7, 1, 0, 0, 0);

        step(); dec_rs1 = 3; dec_rs2 = 3; rob_rs2_ready = 1; rob_rs2_val = 32'h66;
        expect_ops("x3_still_busy", 0, 0, 7, 7, 1, 32'h66, 0, 7);

        step(); write_reg_id = 3; write_ROB_id = 7; write_val = 32'hA; dec_rs1 = 3;
        expect_ops("commit_bypass", 1, 32'hA, 0, 7, 1, 0, 0, 0);

        step(); dec_rs1 = 3;
        expect_ops("x3_committed", 1, 32'hA, 0, 0, 1, 0, 0, 0);

        step(); new_reg_id = 6; new_ROB_id = 2;
        expect_ops("rename_x6", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); write_reg_id = 6; write_ROB_id = 2; write_val = 32'h11;
        new_reg_id = 6; new_ROB_id = 3; dec_rs2 = 6;
        expect_ops("commit_rename_same", 1, 0, 0, 0, 1, 32'h11, 0, 2);

        step(); dec_rs1 = 6; dec_rs2 = 6; rob_rs2_ready = 1; rob_rs2_val = 32'h77;
        expect_ops("x6_retagged", 0, 0, 3, 3, 1, 32'h77, 0, 3);

        step(); new_reg_id = 1; new_ROB_id = 8;
        expect_ops("rename_x1", 1, 0, 0, 0, 1, 0, 0, 0);
        step(); new_reg_id = 2; new_ROB_id = 9;
        expect_ops("rename_x2", 1, 0, 0, 0, 1, 0, 0, 0);
        step(); new_reg_id = 5; new_ROB_id = 10;
        expect_ops("rename_x5", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); rdy_in = 0; clear_flag = 1;
        write_reg_id = 1; write_ROB_id = 8; write_val = 7; dec_rs1 = 2; dec_rs2 = 5;
        expect_ops("paused_lookup", 0, 0, 9, 9, 0, 0, 10, 10);

        step(); dec_rs1 = 1; dec_rs2 = 6;
        expect_ops("pause_froze", 0, 0, 8, 8, 0, 0, 3, 3);

        step(); clear_flag = 1; write_reg_id = 1; write_ROB_id = 8; write_val = 7;
        new_reg_id = 2; new_ROB_id = 12; dec_rs1 = 5;
        expect_ops("flush_cycle", 0, 0, 10, 10, 1, 0, 0, 0);

        step(); dec_rs1 = 1; dec_rs2 = 2;
        expect_ops("after_flush_a", 1, 7, 0, 0, 1, 0, 0, 0);

        step(); dec_rs1 = 6; dec_rs2 = 3;
        expect_ops("after_flush_b", 1, 32'h11, 0, 0, 1, 32'hA, 0, 0);

        step(); new_reg_id = 4; new_ROB_id = 5;
        expect_ops("rename_x4", 1, 0, 0, 0, 1, 0, 0, 0);
        step(); new_reg_id = 7; new_ROB_id = 0;
        expect_ops("rename_x7_tag0", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); dec_rs1 = 4; dec_rs2 = 7;
        expect_ops("tag0_pending", 0, 0, 5, 5, 0, 0, 0, 0);

        step(); rst_n_in = 1'b0; dec_rs1 = 4; dec_rs2 = 1;
        expect_ops("async_reset", 1, 0, 0, 0, 1, 0, 0, 0);

        step(); rst_n_in = 1'b1; dec_rs1 = 6; dec_rs2 = 7;
        expect_ops("post_reset", 1, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_in);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
